// File: rtl/data_mem_ctrl_pkg.sv
// Shared load/store definitions: funct3 access codes and the data-memory controller state encoding.
package data_mem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_ctrl_align.sv
// Byte-lane steering for loads and stores: lane enables, store replication,
// load extension and the legality check for the requested size/alignment.
module lsu_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rext,
  output logic        legal
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rword[{addr_lo, 3'b000} +: 8];
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
    be    = 4'b0000;
    wword = wdata;
    rext  = rword;
    legal = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        legal = (funct3 == F3_B) || !is_store;
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        rext  = (funct3 == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'b0, rbyte};
      end
      F3_H, F3_HU: begin
        legal = !addr_lo[0] && ((funct3 == F3_H) || !is_store);
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rext  = (funct3 == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'b0, rhalf};
      end
      F3_W: begin
        legal = (addr_lo == 2'b00);
        be    = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: word array with byte/half/word access, fixed wait states
// and a combinational busy used by the hazard unit to freeze the pipeline.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        err
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [31:0] mem [Depth];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q, rdata_q;
  logic [2:0]            funct3_q;
  logic                  store_q, done_q, err_q;

  logic                  idle, req, legal_req, commit;
  logic [ADDR_WIDTH+1:0] cur_addr;
  logic [31:0]           cur_wdata;
  logic [2:0]            cur_funct3;
  logic                  cur_store;
  logic [ADDR_WIDTH-1:0] widx;
  logic [3:0]            be;
  logic [31:0]           wword, rext, rword;
  logic                  align_legal;
  logic                  unused_addr;

  // Upper address bits alias onto the array.
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  assign idle = (state_q == StIdle);
  assign req  = mem_read | mem_write;

  // Live inputs while idle (covers the zero-wait commit), latched copy afterwards.
  assign cur_addr   = idle ? addr[ADDR_WIDTH+1:0] : addr_q;
  assign cur_wdata  = idle ? wdata : wdata_q;
  assign cur_funct3 = idle ? funct3 : funct3_q;
  assign cur_store  = idle ? mem_write : store_q;

  assign widx  = cur_addr[ADDR_WIDTH+1:2];
  assign rword = mem[widx];

  lsu_align u_align (
    .funct3   (cur_funct3),
    .addr_lo  (cur_addr[1:0]),
    .is_store (cur_store),
    .wdata    (cur_wdata),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .rext     (rext),
    .legal    (align_legal)
  );

  assign legal_req = req && !(mem_read && mem_write) && align_legal;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (legal_req) begin
          if (WAIT_STATES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
          commit  = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy  = (idle && legal_req) || (state_q == StWait);
  assign rdata = rdata_q;
  assign done  = done_q;
  assign err   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      store_q  <= 1'b0;
      rdata_q  <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && legal_req) begin
        addr_q   <= addr[ADDR_WIDTH+1:0];
        wdata_q  <= wdata;
        funct3_q <= funct3;
        store_q  <= mem_write;
      end
      if (commit && !cur_store) rdata_q <= rext;
      done_q <= (state_d == StResp);
      err_q  <= idle && req && !legal_req;
    end
  end

  // Array has no reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && cur_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (2 and 0 wait states) checked every cycle
// against a byte-addressed memory model and a per-access output timeline.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int unsigned AW       = 10;
  localparam int unsigned MemBytes = 4 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n, rd, wr, busy, done, err;
  logic [1:0][31:0] ad, wd, rdata;
  logic [1:0][2:0]  f3;

  data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .reset(rst_n[0]), .mem_read(rd[0]), .mem_write(wr[0]), .addr(ad[0]),
    .wdata(wd[0]), .funct3(f3[0]), .rdata(rdata[0]), .done(done[0]), .busy(busy[0]),
    .err(err[0])
  );

  data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .reset(rst_n[1]), .mem_read(rd[1]), .mem_write(wr[1]), .addr(ad[1]),
    .wdata(wd[1]), .funct3(f3[1]), .rdata(rdata[1]), .done(done[1]), .busy(busy[1]),
    .err(err[1])
  );

  int               ws [2] = '{2, 0};
  logic [7:0]       mref [2][MemBytes];
  logic [1:0]       e_busy, e_done, e_err, ill_prev;
  logic [1:0][31:0] e_rdata;
  int               n_pass = 0;
  int               n_total = 0;
  bit               run = 1'b0;

  task automatic chk(input string nm, input int s, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %h, want %h", nm, s, act, exp);
  endtask

  always @(negedge clk) begin
    if (run) begin
      for (int s = 0; s < 2; s++) begin
        chk("busy", s, 32'(busy[s]), 32'(e_busy[s]));
        chk("done", s, 32'(done[s]), 32'(e_done[s]));
        chk("err", s, 32'(err[s]), 32'(e_err[s]));
        chk("rdata", s, rdata[s], e_rdata[s]);
      end
    end
  end

  function automatic bit legal_m(bit r, bit w, logic [31:0] a, logic [2:0] f);
    if (r && w) return 1'b0;
    case (f)
      3'b000:  return 1'b1;
      3'b100:  return !w;
      3'b001:  return a[0] == 1'b0;
      3'b101:  return !w && a[0] == 1'b0;
      3'b010:  return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int bidx(logic [31:0] a);
    return int'(a % MemBytes);
  endfunction

  function automatic logic [31:0] load_m(int s, logic [31:0] a, logic [2:0] f);
    int b = bidx(a);
    case (f)
      3'b000:  return 32'($signed(mref[s][b]));
      3'b100:  return {24'b0, mref[s][b]};
      3'b001:  return 32'($signed({mref[s][b+1], mref[s][b]}));
      3'b101:  return {16'b0, mref[s][b+1], mref[s][b]};
      default: return {mref[s][b+3], mref[s][b+2], mref[s][b+1], mref[s][b]};
    endcase
  endfunction

  task automatic store_m(int s, logic [31:0] a, logic [31:0] d, logic [2:0] f);
    int b = bidx(a);
    mref[s][b] = d[7:0];
    if (f != 3'b000) mref[s][b+1] = d[15:8];
    if (f == 3'b010) begin
      mref[s][b+2] = d[23:16];
      mref[s][b+3] = d[31:24];
    end
  endtask

  task automatic begin_cycle();
    for (int s = 0; s < 2; s++) begin
      e_err[s]    = ill_prev[s];
      ill_prev[s] = 1'b0;
      e_busy[s]   = 1'b0;
      e_done[s]   = 1'b0;
      rd[s]       = 1'b0;
      wr[s]       = 1'b0;
      ad[s]       = $urandom;
      wd[s]       = $urandom;
      f3[s]       = 3'($urandom);
    end
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int s, bit r, bit w, logic [31:0] a, logic [31:0] d, logic [2:0] f);
    rd[s] = r;
    wr[s] = w;
    ad[s] = a;
    wd[s] = d;
    f3[s] = f;
  endtask

  // Request held for its whole busy window; the response cycle carries junk inputs.
  task automatic access(int s, bit r, bit w, logic [31:0] a, logic [31:0] d, logic [2:0] f,
                        int holds);
    if (!legal_m(r, w, a, f)) begin
      repeat (holds) begin
        begin_cycle();
        drive(s, r, w, a, d, f);
        ill_prev[s] = 1'b1;
        end_cycle();
      end
    end else begin
      for (int k = 0; k <= ws[s]; k++) begin
        begin_cycle();
        drive(s, r, w, a, d, f);
        e_busy[s] = 1'b1;
        end_cycle();
      end
      begin_cycle();
      rd[s] = 1'($urandom);
      wr[s] = 1'($urandom);
      e_done[s] = 1'b1;
      if (w) store_m(s, a, d, f);
      else e_rdata[s] = load_m(s, a, f);
      end_cycle();
    end
  endtask

  task automatic pin(input string nm, input int s, input logic [31:0] lit);
    chk({nm, " model"}, s, e_rdata[s], lit);
    chk({nm, " dut"}, s, rdata[s], lit);
  endtask

  initial begin
    rst_n = 2'b00; rd = '0; wr = '0; ad = '0; wd = '0; f3 = '0;
    e_busy = '0; e_done = '0; e_err = '0; ill_prev = '0; e_rdata = '0;
    for (int s = 0; s < 2; s++) for (int i = 0; i < int'(MemBytes); i++) mref[s][i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset rdata", s, rdata[s], 32'h0);
      chk("reset done", s, 32'(done[s]), 32'h0);
      chk("reset busy", s, 32'(busy[s]), 32'h0);
      chk("reset err", s, 32'(err[s]), 32'h0);
    end
    rst_n = 2'b11;
    run   = 1'b1;

    // Known contents for the low 64 words that the random phase uses.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++) access(s, 0, 1, 32'(i * 4), 32'h0, F3_W, 1);

    access(0, 0, 1, 32'h10, 32'hDEADBEEF, F3_W, 1);
    access(0, 1, 0, 32'h10, 32'h0, F3_W, 1);
    pin("LW 0x10", 0, 32'hDEADBEEF);
    access(0, 1, 0, 32'h13, 32'h0, F3_B, 1);
    pin("LB 0x13", 0, 32'hFFFFFFDE);
    access(0, 1, 0, 32'h13, 32'h0, F3_BU, 1);
    pin("LBU 0x13", 0, 32'h000000DE);
    access(0, 1, 0, 32'h10, 32'h0, F3_H, 1);
    pin("LH 0x10", 0, 32'hFFFFBEEF);
    access(0, 1, 0, 32'h12, 32'h0, F3_HU, 1);
    pin("LHU 0x12", 0, 32'h0000DEAD);
    access(0, 0, 1, 32'h11, 32'h000000AA, F3_B, 1);
    access(0, 1, 0, 32'h10, 32'h0, F3_W, 1);
    pin("SB then LW", 0, 32'hDEADAAEF);
    access(0, 0, 1, 32'h12, 32'h00001234, F3_H, 1);
    access(0, 1, 0, 32'h10, 32'h0, F3_W, 1);
    pin("SH then LW", 0, 32'h1234AAEF);

    access(0, 1, 0, 32'h12, 32'h0, F3_W, 2);
    access(0, 0, 1, 32'h13, 32'hFFFFFFFF, F3_H, 1);
    access(0, 1, 0, 32'h10, 32'h0, 3'b011, 1);
    access(0, 1, 1, 32'h10, 32'h0, F3_W, 1);
    access(0, 1, 0, 32'h10, 32'h0, F3_W, 1);
    pin("after illegal", 0, 32'h1234AAEF);

    access(0, 0, 1, (32'd4 << AW) + 32'h4, 32'h55, F3_W, 1);
    access(0, 1, 0, 32'h4, 32'h0, F3_W, 1);
    pin("alias", 0, 32'h00000055);

    // Reset in the wait window of a store: nothing commits.
    begin_cycle();
    drive(0, 0, 1, 32'h20, 32'h1, F3_W);
    e_busy[0] = 1'b1;
    end_cycle();
    begin_cycle();
    rst_n[0]   = 1'b0;
    e_rdata[0] = 32'h0;
    end_cycle();
    chk("abort rdata", 0, rdata[0], 32'h0);
    chk("abort done", 0, 32'(done[0]), 32'h0);
    begin_cycle();
    rst_n[0] = 1'b1;
    end_cycle();
    access(0, 1, 0, 32'h20, 32'h0, F3_W, 1);
    pin("aborted SW", 0, 32'h0);

    access(1, 0, 1, 32'h10, 32'hDEADBEEF, F3_W, 1);
    access(1, 1, 0, 32'h10, 32'h0, F3_W, 1);
    pin("ws0 LW 0x10", 1, 32'hDEADBEEF);

    for (int n = 0; n < 250; n++) begin
      for (int s = 0; s < 2; s++) begin
        int          kind = $urandom_range(0, 9);
        bit          r = (kind == 0) || (kind < 5);
        bit          w = (kind == 0) || (kind >= 5);
        logic [2:0]  f;
        logic [31:0] a = {20'($urandom), 4'b0000, 8'($urandom)};
        if ($urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 4))
            0: f = F3_B;
            1: f = F3_H;
            2: f = F3_W;
            3: f = F3_BU;
            default: f = F3_HU;
          endcase
        end else begin
          f = 3'($urandom);
        end
        if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
        access(s, r, w, a, $urandom, f, $urandom_range(1, 2));
      end
    end

    repeat (3) begin
      begin_cycle();
      end_cycle();
    end
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory controller serving the MEM stage of the 5-stage RISC-V core.
- Accepts the load/store request the MEM stage produces (ALU address, store data, funct3, MemRead/MemWrite).
- Performs byte/half/word accesses with sign or zero extension on a word-organised internal array.
- Inserts a configurable number of wait states; raises `busy` so the hazard logic can freeze the pipeline.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array holds 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 2, extra cycles per access (0..15); 0 gives single-cycle response.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_read  input  1  load request (MemRead_MEM).
- mem_write  input  1  store request (MemWrite_MEM).
- addr  input  32  byte address (ALU_OUT_MEM).
- wdata  input  32  store data (REG_DATA2_MEM).
- funct3  input  3  access size/sign (funct3_MEM).
- rdata  output  32  registered, extended load result.
- done  output  1  one-cycle pulse: access complete, rdata valid for loads.
- busy  output  1  combinational stall request to pipeline.
- err  output  1  one-cycle pulse: misaligned/illegal request rejected.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0, rdata=0, done=0, err=0.
  - Array contents are not cleared.
  - Reset during WAIT aborts the access; a pending store is not committed.
- Request definition: in IDLE, a request is mem_read|mem_write. Inputs are sampled only in IDLE; the requester must hold them stable while busy=1.
- Legality:
  - funct3 000 (B), 100 (BU): any address.
  - 001 (H), 101 (HU): addr[0]=0.
  - 010 (W): addr[1:0]=0.
  - Stores accept only 000/001/010.
  - mem_read & mem_write both high is illegal.
- Illegal request in IDLE:
  - err=1 for the next cycle only; stay in IDLE; busy=0; no array change; rdata unchanged.
  - The same request held on the following cycle raises err again.
- Legal request in IDLE:
  - Latch addr, wdata, funct3, type.
  - Load counter with WAIT_STATES; go to WAIT, or directly to RESP if WAIT_STATES=0.
- WAIT: decrement the counter each cycle; when it reaches 0, go to RESP.
- Commit edge: the edge that enters RESP.
  - Store: write the enabled byte lanes.
  - Load: register the extended data into rdata.
- RESP: done=1 for exactly one cycle, busy=0, then IDLE. Request inputs are ignored in RESP.
- busy = (IDLE & legal request) | WAIT.
- Latency: request in cycle 0 gives done in cycle WAIT_STATES+1.
  - busy is high in cycles 0..WAIT_STATES.
  - The pipeline advances on the edge ending the RESP cycle.
- Byte lanes:
  - Word index is addr[ADDR_WIDTH+1:2]; upper address bits are ignored (aliasing wrap-around).
  - B/BU select lane addr[1:0]; H/HU select half addr[1].
  - SB replicates wdata[7:0] into the selected lane; SH writes wdata[15:0] into the selected half; SW writes all lanes.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- Load result is formed from the array contents before the commit edge. There is no read-after-write hazard within one access, since accesses are serialised.

Decomposition:
- Shared package (core-wide, reused by ID/EX):
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
- Sub-module `lsu_align` (combinational):
  - Inputs: funct3, addr[1:0], wdata, read word.
  - Outputs: byte enables[3:0], aligned store word, extended load word, legal flag.
- FSM, counter and array stay in data_mem_ctrl.

Test Plan:
- WAIT_STATES=2; SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> busy high cycles 0..2, done in cycle 3, rdata=0xDEADBEEF.
- After the above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB addr=0x11 wdata=0x000000AA, then LW 0x10 -> 0xDEADAABE... no: 0xDEADAAEF; SH addr=0x12 wdata=0x1234, then LW -> 0x1234AAEF.
- LW addr=0x12 and SH addr=0x13 -> err one cycle each, busy=0, done=0, memory unchanged; funct3=011 load -> err; mem_read&mem_write -> err.
- Alias wrap: SW addr=(4<<ADDR_WIDTH)+0x4 wdata=0x55 -> LW 0x4 returns 0x00000055.
- Assert reset low during WAIT of SW 0x20 wdata=0x1 (previously 0) -> rdata=0, done=0, state IDLE; later LW 0x20 returns 0. Re-run the first scenario with WAIT_STATES=0 -> done in cycle 1.
